cc_miss_scheduler: RTL and testbench

CC_MISS_SCHEDULER -- requirements
Module: cc_miss_scheduler

---
 rtl/cc_pkg.sv | 21 ++
 rtl/cc_outstanding_cnt.sv | 43 ++++
 rtl/cc_miss_scheduler.sv | 140 ++++++++++++++
 tb/tb_cc_miss_scheduler.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cc_pkg.sv
// Shared definitions for the cache-controller miss path: FSM states,
// AXI read-burst constants and line geometry.
package cc_pkg;

    localparam int unsigned ADDR_W     = 32;
    localparam int unsigned CNT_W      = 3;
    localparam int unsigned BEAT_W     = 3;
    localparam int unsigned LINE_BEATS = 8;
    // Byte-offset bits within one 8-byte beat; cleared on araddr.
    localparam int unsigned BEAT_OFF_W = 3;

    localparam logic [3:0] ARLEN_LINE   = 4'd7;
    localparam logic [2:0] ARSIZE_8B    = 3'd3;
    localparam logic [1:0] ARBURST_WRAP = 2'b10;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        AR_REQ = 1'b1
    } cc_state_e;

endpackage

// File: rtl/cc_outstanding_cnt.sv
// Count of AR bursts issued whose last R beat has not yet arrived.
// Simultaneous issue and completion cancel; the count saturates at both ends.
module cc_outstanding_cnt
    import cc_pkg::*;
#(
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc_i,
    input  logic             dec_i,
    output logic [CNT_W-1:0] count_o,
    output logic             below_max_o,
    output logic             nonzero_o
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc_i && !dec_i && (count_q != MAX_CNT)) begin
            count_d = count_q + CNT_W'(1);
        end else if (dec_i && !inc_i && (count_q != '0)) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o     = count_q;
    assign below_max_o = (count_q < MAX_CNT);
    assign nonzero_o   = (count_q != '0);

endmodule

// File: rtl/cc_miss_scheduler.sv
// Turns tag-compare misses into critical-word-first AXI WRAP bursts and
// tracks the returning R beats to pace outstanding line fills.
module cc_miss_scheduler
    import cc_pkg::*;
#(
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              miss_valid_i,
    input  logic [ADDR_W-1:0] miss_addr_i,
    output logic              miss_ready_o,

    output logic              mem_arvalid_o,
    output logic [ADDR_W-1:0] mem_araddr_o,
    output logic [3:0]        mem_arlen_o,
    output logic [2:0]        mem_arsize_o,
    output logic [1:0]        mem_arburst_o,
    input  logic              mem_arready_i,

    input  logic              mem_rvalid_i,
    input  logic              mem_rlast_i,
    output logic              mem_rready_o,

    input  logic              miss_addr_fifo_full_i,
    output logic              miss_addr_fifo_wren_o,
    output logic [ADDR_W-1:0] miss_addr_fifo_wdata_o,

    output logic              fill_done_o,
    output logic [CNT_W-1:0]  outstanding_o,
    output logic              idle_o,
    output logic              proto_err_o
);

    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LINE_BEATS - 1);

    cc_state_e                    state_q;
    cc_state_e                    state_d;
    logic [ADDR_W-1:BEAT_OFF_W]   addr_q;
    logic [ADDR_W-1:BEAT_OFF_W]   addr_d;
    logic [BEAT_W-1:0]            beat_q;
    logic [BEAT_W-1:0]            beat_d;
    logic                         err_q;
    logic                         err_d;

    logic accept;
    logic ar_hs;
    logic r_hs;
    logic below_max;
    logic nonzero;

    cc_outstanding_cnt #(
        .MAX_OUTSTANDING (MAX_OUTSTANDING)
    ) u_outstanding_cnt (
        .clk         (clk),
        .rst_n       (rst_n),
        .inc_i       (ar_hs),
        .dec_i       (fill_done_o),
        .count_o     (outstanding_o),
        .below_max_o (below_max),
        .nonzero_o   (nonzero)
    );

    // A completing fill frees a slot this cycle; the new AR cannot issue
    // before the decrement lands, so the limit still holds.
    assign miss_ready_o  = (state_q == IDLE) & ~miss_addr_fifo_full_i
                         & (below_max | fill_done_o) & rst_n;
    assign accept        = miss_valid_i & miss_ready_o;

    assign miss_addr_fifo_wren_o  = accept;
    assign miss_addr_fifo_wdata_o = miss_addr_i;

    assign mem_arvalid_o = (state_q == AR_REQ) & rst_n;
    assign mem_araddr_o  = {addr_q, {BEAT_OFF_W{1'b0}}};
    assign mem_arlen_o   = ARLEN_LINE;
    assign mem_arsize_o  = ARSIZE_8B;
    assign mem_arburst_o = ARBURST_WRAP;
    assign ar_hs         = mem_arvalid_o & mem_arready_i;

    assign mem_rready_o  = nonzero & rst_n;
    assign r_hs          = mem_rvalid_i & mem_rready_o;
    assign fill_done_o   = r_hs & mem_rlast_i;

    assign idle_o        = (state_q == IDLE) & ~nonzero;
    assign proto_err_o   = err_q;

    // Next state, captured address and beat/length checking.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        beat_d  = beat_q;
        err_d   = err_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = AR_REQ;
                    addr_d  = miss_addr_i[ADDR_W-1:BEAT_OFF_W];
                end
            end
            AR_REQ: begin
                if (mem_arready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Any length violation resyncs the counter to the start of a burst.
        if (r_hs) begin
            if (mem_rlast_i) begin
                beat_d = '0;
                if (beat_q != LAST_BEAT) begin
                    err_d = 1'b1;
                end
            end else if (beat_q == LAST_BEAT) begin
                beat_d = '0;
                err_d  = 1'b1;
            end else begin
                beat_d = beat_q + BEAT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            beat_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            beat_q  <= beat_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_cc_miss_scheduler.sv
// Directed bench for cc_miss_scheduler; FIFO writes, AR handshakes and fill
// completions are checked against queued expectations by a separate monitor.
module tb_cc_miss_scheduler;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        miss_valid_i;
    logic [31:0] miss_addr_i;
    logic        miss_ready_o;
    logic        mem_arvalid_o;
    logic [31:0] mem_araddr_o;
    logic [3:0]  mem_arlen_o;
    logic [2:0]  mem_arsize_o;
    logic [1:0]  mem_arburst_o;
    logic        mem_arready_i;
    logic        mem_rvalid_i;
    logic        mem_rlast_i;
    logic        mem_rready_o;
    logic        miss_addr_fifo_full_i;
    logic        miss_addr_fifo_wren_o;
    logic [31:0] miss_addr_fifo_wdata_o;
    logic        fill_done_o;
    logic [2:0]  outstanding_o;
    logic        idle_o;
    logic        proto_err_o;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] exp_wr[$];
    logic [31:0] exp_ar[$];
    logic [2:0]  exp_fill[$];

    cc_miss_scheduler #(.MAX_OUTSTANDING(4)) dut (
        .clk                    (clk),
        .rst_n                  (rst_n),
        .miss_valid_i           (miss_valid_i),
        .miss_addr_i            (miss_addr_i),
        .miss_ready_o           (miss_ready_o),
        .mem_arvalid_o          (mem_arvalid_o),
        .mem_araddr_o           (mem_araddr_o),
        .mem_arlen_o            (mem_arlen_o),
        .mem_arsize_o           (mem_arsize_o),
        .mem_arburst_o          (mem_arburst_o),
        .mem_arready_i          (mem_arready_i),
        .mem_rvalid_i           (mem_rvalid_i),
        .mem_rlast_i            (mem_rlast_i),
        .mem_rready_o           (mem_rready_o),
        .miss_addr_fifo_full_i  (miss_addr_fifo_full_i),
        .miss_addr_fifo_wren_o  (miss_addr_fifo_wren_o),
        .miss_addr_fifo_wdata_o (miss_addr_fifo_wdata_o),
        .fill_done_o            (fill_done_o),
        .outstanding_o          (outstanding_o),
        .idle_o                 (idle_o),
        .proto_err_o            (proto_err_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic unexpected(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: event with no expectation queued at %0t", name, $time);
    endtask

    // Monitor: compares every observed output event with the queued expectation.
    always @(negedge clk) begin
        if (miss_addr_fifo_wren_o) begin
            if (exp_wr.size() == 0) unexpected("fifo_wren");
            else chk("fifo_wdata", miss_addr_fifo_wdata_o, exp_wr.pop_front());
        end
        if (mem_arvalid_o && mem_arready_i) begin
            if (exp_ar.size() == 0) unexpected("ar_handshake");
            else begin
                chk("araddr", mem_araddr_o, exp_ar.pop_front());
                chk("arlen", 32'(mem_arlen_o), 32'd7);
                chk("arsize", 32'(mem_arsize_o), 32'd3);
                chk("arburst", 32'(mem_arburst_o), 32'd2);
            end
        end
        if (fill_done_o) begin
            if (exp_fill.size() == 0) unexpected("fill_done");
            else chk("fill_outstanding", 32'(outstanding_o), 32'(exp_fill.pop_front()));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic accept(input logic [31:0] a);
        logic [31:0] ar;
        ar = {a[31:3], 3'b000};
        miss_valid_i = 1'b1;
        miss_addr_i  = a;
        #1;
        chk("miss_ready_accept", 32'(miss_ready_o), 32'd1);
        exp_wr.push_back(a);
        exp_ar.push_back(ar);
        tick();
        miss_valid_i = 1'b0;
    endtask

    task automatic do_miss(input logic [31:0] a, input int wait_cyc);
        logic [31:0] ar;
        ar = {a[31:3], 3'b000};
        accept(a);
        for (int i = 0; i < wait_cyc; i++) begin
            #1;
            chk("arvalid_hold", 32'(mem_arvalid_o), 32'd1);
            chk("araddr_hold", mem_araddr_o, ar);
            tick();
        end
        mem_arready_i = 1'b1;
        tick();
        mem_arready_i = 1'b0;
    endtask

    task automatic send_beats(input int n, input bit last, input logic [2:0] exp_out,
                              input bit ar_on_last);
        for (int i = 0; i < n; i++) begin
            mem_rvalid_i = 1'b1;
            mem_rlast_i  = last && (i == n - 1);
            if (ar_on_last && (i == n - 1)) mem_arready_i = 1'b1;
            #1;
            chk("rready_beat", 32'(mem_rready_o), 32'd1);
            if (mem_rlast_i) exp_fill.push_back(exp_out);
            tick();
        end
        mem_rvalid_i  = 1'b0;
        mem_rlast_i   = 1'b0;
        mem_arready_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n                 = 1'b0;
        miss_valid_i          = 1'b1;
        miss_addr_i           = 32'h0000_0040;
        mem_arready_i         = 1'b0;
        mem_rvalid_i          = 1'b1;
        mem_rlast_i           = 1'b0;
        miss_addr_fifo_full_i = 1'b0;

        // Reset: outputs gated while low, registered state cleared after an edge.
        #1;
        chk("rst_miss_ready", 32'(miss_ready_o), 32'd0);
        chk("rst_arvalid", 32'(mem_arvalid_o), 32'd0);
        chk("rst_wren", 32'(miss_addr_fifo_wren_o), 32'd0);
        chk("rst_rready", 32'(mem_rready_o), 32'd0);
        tick();
        chk("rst_fill_done", 32'(fill_done_o), 32'd0);
        chk("rst_outstanding", 32'(outstanding_o), 32'd0);
        chk("rst_idle", 32'(idle_o), 32'd1);
        chk("rst_proto_err", 32'(proto_err_o), 32'd0);
        chk("rst_araddr", mem_araddr_o, 32'd0);
        miss_valid_i = 1'b0;
        mem_rvalid_i = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();

        // Single miss, AR stalled two cycles, full 8-beat fill.
        do_miss(32'h0000_1238, 2);
        chk("single_outstanding", 32'(outstanding_o), 32'd1);
        chk("single_not_idle", 32'(idle_o), 32'd0);
        send_beats(8, 1'b1, 3'd1, 1'b0);
        chk("single_done_outstanding", 32'(outstanding_o), 32'd0);
        chk("single_idle", 32'(idle_o), 32'd1);
        chk("single_rready_off", 32'(mem_rready_o), 32'd0);
        chk("single_no_err", 32'(proto_err_o), 32'd0);

        // Fill the outstanding window, then reopen it with one completion.
        do_miss(32'h0000_0100, 0);
        do_miss(32'h0000_0208, 0);
        do_miss(32'h0000_0310, 0);
        do_miss(32'h0000_041C, 0);
        chk("window_full_count", 32'(outstanding_o), 32'd4);
        miss_valid_i = 1'b1;
        miss_addr_i  = 32'h0000_0500;
        #1;
        chk("window_full_ready", 32'(miss_ready_o), 32'd0);
        send_beats(7, 1'b0, 3'd0, 1'b0);
        chk("window_still_closed", 32'(miss_ready_o), 32'd0);
        mem_rvalid_i = 1'b1;
        mem_rlast_i  = 1'b1;
        #1;
        chk("reopen_fill_done", 32'(fill_done_o), 32'd1);
        chk("reopen_ready", 32'(miss_ready_o), 32'd1);
        exp_fill.push_back(3'd4);
        exp_wr.push_back(32'h0000_0500);
        exp_ar.push_back(32'h0000_0500);
        tick();
        miss_valid_i = 1'b0;
        mem_rvalid_i = 1'b0;
        mem_rlast_i  = 1'b0;
        chk("reopen_count", 32'(outstanding_o), 32'd3);
        mem_arready_i = 1'b1;
        tick();
        mem_arready_i = 1'b0;
        chk("refill_count", 32'(outstanding_o), 32'd4);
        send_beats(8, 1'b1, 3'd4, 1'b0);
        send_beats(8, 1'b1, 3'd3, 1'b0);
        chk("drain_to_two", 32'(outstanding_o), 32'd2);

        // AR handshake on the same edge as an rlast handshake.
        accept(32'h0000_0C04);
        send_beats(8, 1'b1, 3'd2, 1'b1);
        chk("coincident_count", 32'(outstanding_o), 32'd2);
        chk("coincident_ar_done", 32'(mem_arvalid_o), 32'd0);
        send_beats(8, 1'b1, 3'd2, 1'b0);
        send_beats(8, 1'b1, 3'd1, 1'b0);
        chk("drained_idle", 32'(idle_o), 32'd1);

        // FIFO full blocks accept; full during AR_REQ does not stall the AR.
        miss_addr_fifo_full_i = 1'b1;
        miss_valid_i          = 1'b1;
        miss_addr_i           = 32'h0000_0600;
        #1;
        chk("full_blocks_ready", 32'(miss_ready_o), 32'd0);
        tick();
        chk("full_no_ar", 32'(mem_arvalid_o), 32'd0);
        miss_addr_fifo_full_i = 1'b0;
        accept(32'h0000_0600);
        miss_addr_fifo_full_i = 1'b1;
        #1;
        chk("full_ar_valid", 32'(mem_arvalid_o), 32'd1);
        mem_arready_i = 1'b1;
        tick();
        mem_arready_i         = 1'b0;
        miss_addr_fifo_full_i = 1'b0;
        chk("full_ar_count", 32'(outstanding_o), 32'd1);
        send_beats(8, 1'b1, 3'd1, 1'b0);

        // Short burst: rlast on beat 5 is a sticky error; next full burst fills.
        do_miss(32'h0000_0700, 0);
        send_beats(5, 1'b1, 3'd1, 1'b0);
        chk("short_err", 32'(proto_err_o), 32'd1);
        chk("short_count", 32'(outstanding_o), 32'd0);
        do_miss(32'h0000_080F, 1);
        send_beats(8, 1'b1, 3'd1, 1'b0);
        chk("short_err_sticky", 32'(proto_err_o), 32'd1);
        chk("after_short_idle", 32'(idle_o), 32'd1);

        // Reset mid-burst during beat 4 abandons the burst.
        do_miss(32'h0000_0900, 0);
        send_beats(3, 1'b0, 3'd0, 1'b0);
        mem_rvalid_i = 1'b1;
        rst_n        = 1'b0;
        #1;
        chk("midrst_rready", 32'(mem_rready_o), 32'd0);
        tick();
        rst_n        = 1'b1;
        mem_rvalid_i = 1'b0;
        #1;
        chk("midrst_count", 32'(outstanding_o), 32'd0);
        chk("midrst_rready_after", 32'(mem_rready_o), 32'd0);
        chk("midrst_idle", 32'(idle_o), 32'd1);
        chk("midrst_err_clear", 32'(proto_err_o), 32'd0);
        do_miss(32'h0000_0A00, 0);
        send_beats(8, 1'b1, 3'd1, 1'b0);
        chk("post_rst_no_err", 32'(proto_err_o), 32'd0);

        // Eight beats without rlast is a length error with no completion.
        do_miss(32'h0000_0B00, 0);
        send_beats(8, 1'b0, 3'd0, 1'b0);
        chk("long_err", 32'(proto_err_o), 32'd1);
        chk("long_count", 32'(outstanding_o), 32'd1);
        send_beats(8, 1'b1, 3'd1, 1'b0);
        chk("long_final_idle", 32'(idle_o), 32'd1);

        tick();
        tick();
        chk("exp_wr_left", 32'(exp_wr.size()), 32'd0);
        chk("exp_ar_left", 32'(exp_ar.size()), 32'd0);
        chk("exp_fill_left", 32'(exp_fill.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
